// File: rtl/lpc_pkg.sv
// Constants and FSM state encoding shared by the LPC synthesis and inverse filters.
package lpc_pkg;

    localparam int FRAME_LEN = 160;
    localparam int ORDER     = 10;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 12;
    localparam int ACC_W     = 40;
    localparam int ADDR_W    = 8;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        WRITE,
        DONE
    } state_e;

endpackage

// File: rtl/sfilter_mac.sv
// Multiply-accumulate datapath for the synthesis filter: Q3.12 products summed
// into a wide accumulator, then rounded half-up and saturated to the sample width.
module sfilter_mac
    import lpc_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_i,
    input  logic                     accum_i,
    input  logic signed [DATA_W-1:0] residue_i,
    input  logic signed [DATA_W-1:0] y_i,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic signed [DATA_W-1:0] y_o
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(2 ** (COEF_FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  rounded;

    assign prod = PROD_W'(y_i) * PROD_W'(coef_i);

    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = ACC_W'(residue_i) <<< COEF_FRAC;
        end else if (accum_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Legal coefficients keep the accumulator in range, so only the output saturates.
    always_comb begin
        rounded = (acc_q + HALF) >>> COEF_FRAC;
        if (rounded > SAT_MAX) begin
            y_o = DATA_W'(SAT_MAX);
        end else if (rounded < SAT_MIN) begin
            y_o = DATA_W'(SAT_MIN);
        end else begin
            y_o = rounded[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/sfilter.sv
// LPC all-pole synthesis filter: sequences one frame of residue through the
// MAC datapath and writes reconstructed speech back to the output buffer.
module sfilter
    import lpc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              ready,
    output logic [ORDER-1:0]  a_rsel,
    input  logic [COEF_W-1:0] a_rdata,
    output logic [ADDR_W-1:0] residue_raddr,
    input  logic [DATA_W-1:0] residue_rdata,
    output logic [ADDR_W-1:0] y_raddr,
    input  logic [DATA_W-1:0] y_rdata,
    output logic [ADDR_W-1:0] y_waddr,
    output logic [DATA_W-1:0] y_wdata,
    output logic              y_wen
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0]  k_last;
    logic [DATA_W-1:0] mac_y;

    // History before n=0 is zero, so early samples use only n taps.
    assign k_last = (n_q < ADDR_W'(ORDER)) ? n_q[CNT_W-1:0] : CNT_W'(ORDER);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    n_d     = '0;
                    k_d     = '0;
                end
            end
            LOAD: begin
                if (n_q != '0) begin
                    state_d = MAC;
                    k_d     = CNT_W'(1);
                end else begin
                    state_d = WRITE;
                end
            end
            MAC: begin
                if (k_q == k_last) begin
                    state_d = WRITE;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            WRITE: begin
                if (n_q == ADDR_W'(FRAME_LEN - 1)) begin
                    state_d = DONE;
                end else begin
                    n_d     = n_q + ADDR_W'(1);
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q == LOAD) || (state_q == MAC) || (state_q == WRITE);
        ready         = (state_q == DONE);
        y_wen         = (state_q == WRITE);
        residue_raddr = n_q;
        y_waddr       = n_q;
        a_rsel        = '0;
        y_raddr       = '0;
        y_wdata       = '0;
        if (state_q == MAC) begin
            a_rsel  = ORDER'(1) << (k_q - CNT_W'(1));
            y_raddr = n_q - ADDR_W'(k_q);
        end
        if (state_q == WRITE) begin
            y_wdata = mac_y;
        end
    end

    sfilter_mac u_mac (
        .clk       (clk),
        .reset     (reset),
        .load_i    (state_q == LOAD),
        .accum_i   (state_q == MAC),
        .residue_i (residue_rdata),
        .y_i       (y_rdata),
        .coef_i    (a_rdata),
        .y_o       (mac_y)
    );

endmodule
